bj_operand_fwd_unit: RTL and testbench
======================================

// Module: bj_operand_fwd_unit
// PURPOSE
// - Parametrised ID-stage operand forwarding and hazard unit for branch/jump compare and other early readers.
// - Keeps a private tag pipeline of in-flight register writers (slot 0 = EX ... slot DEPTH-1).
// - Per read port, returns the youngest in-flight value for the register, or the regfile value.
// - Raises stall while a matching writer has not yet produced its result (load-use, hilo/cp0 late results).
// PARAMETERS
// NUM_RD  2   number of ID read ports
// DEPTH   3   in-flight writer slots tracked (0=EX,1=MEM,2=WB)
// DW      32  data width
// AW      5   register address width
// SW      2   width of ready-stage field; must satisfy 2**SW >= DEPTH
// PORTS
// clk          in   1          pipeline clock
// rst_n        in   1          asynchronous active-low reset
// adv          in   1          EX-onward pipeline advances this cycle
// flush        in   1          kill all in-flight writers (exception/eret)
// id_valid     in   1          ID holds a valid instruction
// id_we        in   1          ID instruction writes a GPR
// id_rw        in   AW         ID destination register
// id_rdy_stg   in   SW         slot index at which its result becomes valid (ALU=0, load/hilo/cp0=1)
// rd_en        in   NUM_RD     read port r is used by the ID instruction
// rd_addr      in   NUM_RD*AW  source register per port (port r at [r*AW +: AW])
// rf_rdata     in   NUM_RD*DW  regfile read data per port
// stg_data     in   DEPTH*DW   final result of the instruction in slot i (already muxed ALU/hilo/cp0/load)
// fwd_rdata    out  NUM_RD*DW  forwarded operand per port
// fwd_hit      out  NUM_RD     port r took a forwarded value
// stall        out  1          ID must hold; a matching result is not ready
// stall_cnt    out  16         saturating count of stalled cycles
// BEHAVIOUR
// - Slot state: vld, rw[AW], rdy[SW]. Reset: all vld=0, stall_cnt=0; hence stall=0, fwd_hit=0 and
//   fwd_rdata=rf_rdata out of reset.
// - Slot update, priority flush > adv > hold:
//   flush=1: all vld<=0 next edge, regardless of adv.
//   adv=1: slot[i]<=slot[i-1] for i>=1; slot[0] loads ID when id_valid & id_we & id_rw!=0 & ~stall,
//          else loads a bubble (vld=0). The oldest slot drops out.
//   adv=0: all slots hold; stall is still recomputed every cycle.
// - Lookup per port r (combinational, zero latency): active when rd_en[r] & rd_addr!=0.
//   Scan slots 0..DEPTH-1; first slot with vld & rw==rd_addr is the match (youngest wins).
//   Match in slot i with rdy<=i: fwd_rdata=stg_data[i], fwd_hit[r]=1.
//   Match with rdy>i: value not ready; port requests a stall and fwd_rdata=rf_rdata (don't-care).
//   No match, or port inactive, or rd_addr==0: fwd_rdata=rf_rdata, fwd_hit[r]=0.
//   An older slot is never used when a younger slot matches, even if the younger one is not ready.
// - stall = OR of per-port stall requests. Only the ID instruction is held; slot 0 receives a
//   bubble on each stalled adv, so a stall lasts (rdy - i) advancing cycles.
// - id_rdy_stg >= DEPTH: writer never forwards and stalls readers until it leaves the window.
// - stall_cnt: +1 on every clock where stall=1, saturating at 16'hFFFF; cleared only by reset.
// - Reset asserted mid-operation: slots and counter clear immediately (async); stall drops combinationally.
// - flush with stall=1: stall is still 1 in the flush cycle, and 0 from the next cycle,
//   since all slots are empty.
// TESTING
// - ALU r5 in slot0 (rdy=0), stg_data[0]=0x1234, read r5 port0 -> fwd_rdata0=0x1234, hit=1, stall=0.
// - Load r7 in slot0 (rdy=1), read r7 -> stall=1 for exactly 1 adv cycle; then slot1, fwd=stg_data[1].
// - r3 in slot0 (0xAAAA) and slot1 (0xBBBB), both ready -> port1 gets 0xAAAA (youngest).
// - rd_addr=0 with slot0 rw=0 forced -> rf_rdata passes, hit=0; id_rw=0 never allocates vld.
// - Load-use stall, then flush=1 -> next cycle stall=0, fwd_rdata=rf_rdata, all slots empty.
// - adv=0 during stall for 5 cycles -> slots hold, stall_cnt +5; preload 0xFFFE, 3 stalls -> 0xFFFF.

Source files
------------

// File: rtl/bj_operand_fwd_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bj_operand_fwd_unit
// ID-stage operand forwarding and hazard unit for branch/jump compare and other
// early readers. A private tag pipeline tracks in-flight register writers
// (slot 0 = EX, slot 1 = MEM, ... slot DEPTH-1). Each ID read port receives the
// youngest in-flight value of its register, or the regfile value when no
// writer matches. When the youngest matching writer has not produced its
// result yet, ID is stalled.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   adv          EX-onward pipeline advances this cycle
//   flush        kill all in-flight writers
//   id_valid     ID holds a valid instruction
//   id_we        ID instruction writes a GPR
//   id_rw        ID destination register
//   id_rdy_stg   slot index at which the ID result becomes valid
//   rd_en        per-port read enable
//   rd_addr      per-port source register (port r at [r*AW +: AW])
//   rf_rdata     per-port regfile read data
//   stg_data     final result of the instruction in slot i (slot i at [i*DW +: DW])
//   fwd_rdata    per-port forwarded operand
//   fwd_hit      port took a forwarded value
//   stall        ID must hold
//   stall_cnt    saturating count of stalled cycles
// -----------------------------------------------------------------------------
module bj_operand_fwd_unit #(
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int SW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic                 id_we,
  input  logic [AW-1:0]        id_rw,
  input  logic [SW-1:0]        id_rdy_stg,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD*DW-1:0] rf_rdata,
  input  logic [DEPTH*DW-1:0]  stg_data,
  output logic [NUM_RD*DW-1:0] fwd_rdata,
  output logic [NUM_RD-1:0]    fwd_hit,
  output logic                 stall,
  output logic [15:0]          stall_cnt
);

  // Slot state: valid flag, destination register, ready stage.
  logic [DEPTH-1:0] slot_vld;
  logic [AW-1:0]    slot_rw  [DEPTH];
  logic [SW-1:0]    slot_rdy [DEPTH];

  logic [NUM_RD-1:0] port_stall;
  logic [NUM_RD-1:0] port_seen;
  logic              alloc;

  // A stalled ID instruction must not enter EX; slot 0 then takes a bubble.
  assign alloc = id_valid & id_we & (id_rw != '0) & ~stall;

  // Lookup: scan from the youngest slot; the first valid tag match decides
  // the outcome for that port, ready or not.
  // NOTE: every variable driven here gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_rdata  = rf_rdata;
    fwd_hit    = '0;
    port_stall = '0;
    port_seen  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_en[r] && (rd_addr[r*AW +: AW] != '0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!port_seen[r] && slot_vld[i] && (slot_rw[i] == rd_addr[r*AW +: AW])) begin
            port_seen[r] = 1'b1;
            if (int'(slot_rdy[i]) <= i) begin
              fwd_rdata[r*DW +: DW] = stg_data[i*DW +: DW];
              fwd_hit[r]            = 1'b1;
            end else begin
              port_stall[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall = |port_stall;

  // Valid flags carry all the control meaning, so only they need reset.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge value of its neighbour during the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
    end else if (flush) begin
      slot_vld <= '0;
    end else if (adv) begin
      for (int i = DEPTH-1; i >= 1; i--) begin
        slot_vld[i] <= slot_vld[i-1];
      end
      slot_vld[0] <= alloc;
    end
  end

  // NOTE: tag/ready payload is deliberately left without reset: it is only
  // ever looked at through slot_vld, and keeping it reset-free lets it map to
  // plain flops without reset routing.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = DEPTH-1; i >= 1; i--) begin
        slot_rw[i]  <= slot_rw[i-1];
        slot_rdy[i] <= slot_rdy[i-1];
      end
      slot_rw[0]  <= id_rw;
      slot_rdy[0] <= id_rdy_stg;
    end
  end

  // Stalled-cycle counter, saturating; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bj_operand_fwd_unit.sv
`timescale 1ns/1ps
module tb_bj_operand_fwd_unit;

  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int SW     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 adv, flush;
  logic                 id_valid, id_we;
  logic [AW-1:0]        id_rw;
  logic [SW-1:0]        id_rdy_stg;
  logic [NUM_RD-1:0]    rd_en;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rf_rdata;
  logic [DEPTH*DW-1:0]  stg_data;
  logic [NUM_RD*DW-1:0] fwd_rdata;
  logic [NUM_RD-1:0]    fwd_hit;
  logic                 stall;
  logic [15:0]          stall_cnt;

  bj_operand_fwd_unit #(
    .NUM_RD(NUM_RD), .DEPTH(DEPTH), .DW(DW), .AW(AW), .SW(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flush(flush),
    .id_valid(id_valid), .id_we(id_we), .id_rw(id_rw), .id_rdy_stg(id_rdy_stg),
    .rd_en(rd_en), .rd_addr(rd_addr), .rf_rdata(rf_rdata), .stg_data(stg_data),
    .fwd_rdata(fwd_rdata), .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight writers, index = stages since EX.
  typedef struct {
    bit vld;
    int rw;
    int rdy;
  } wr_t;

  wr_t pipe[$];
  int  m_cnt;

  logic [NUM_RD*DW-1:0] e_data;
  logic [NUM_RD-1:0]    e_hit;
  logic                 e_stall;

  int n_asserts = 0;
  int n_fail    = 0;

  function automatic void model_clear();
    wr_t b;
    b.vld = 1'b0; b.rw = 0; b.rdy = 0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
  endfunction

  // Youngest matching writer decides: ready -> its stage result, else stall.
  function automatic void model_eval();
    e_data  = rf_rdata;
    e_hit   = '0;
    e_stall = 1'b0;
    for (int r = 0; r < NUM_RD; r++) begin
      int a;
      a = int'(rd_addr[r*AW +: AW]);
      if (rd_en[r] && a != 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (pipe[i].vld && pipe[i].rw == a) begin
            if (pipe[i].rdy <= i) begin
              e_data[r*DW +: DW] = stg_data[i*DW +: DW];
              e_hit[r] = 1'b1;
            end else begin
              e_stall = 1'b1;
            end
            break;
          end
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    model_eval();
    n_asserts++;
    assert (fwd_rdata === e_data) else begin
      n_fail++;
      $error("FAIL %s fwd_rdata observed=%h expected=%h", tag, fwd_rdata, e_data);
    end
    n_asserts++;
    assert (fwd_hit === e_hit) else begin
      n_fail++;
      $error("FAIL %s fwd_hit observed=%b expected=%b", tag, fwd_hit, e_hit);
    end
    n_asserts++;
    assert (stall === e_stall) else begin
      n_fail++;
      $error("FAIL %s stall observed=%b expected=%b", tag, stall, e_stall);
    end
    n_asserts++;
    assert (stall_cnt === 16'(m_cnt)) else begin
      n_fail++;
      $error("FAIL %s stall_cnt observed=%h expected=%h", tag, stall_cnt, 16'(m_cnt));
    end
  endtask

  // Advance one clock; model follows the same edge using the pre-edge inputs.
  task automatic tick();
    wr_t w;
    model_eval();
    if (e_stall && m_cnt < 65535) m_cnt++;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) pipe[i].vld = 1'b0;
    end else if (adv) begin
      w.vld = id_valid && id_we && (id_rw != 0) && !e_stall;
      w.rw  = int'(id_rw);
      w.rdy = int'(id_rdy_stg);
      void'(pipe.pop_back());
      pipe.push_front(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic we, input int rw, input int rdy);
    id_valid   = v;
    id_we      = we;
    id_rw      = AW'(rw);
    id_rdy_stg = SW'(rdy);
  endtask

  task automatic set_rd(input int p, input logic en, input int a);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle_id();
    set_id(1'b0, 1'b0, 0, 0);
    rd_en = '0;
    rd_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    adv = 1'b0; flush = 1'b0;
    idle_id();
    rf_rdata = {32'h0F0F_0F0F, 32'h1111_2222};
    stg_data = '0;
    model_clear();
    m_cnt = 0;

    // Reset state, with a read asking for r1.
    set_rd(0, 1'b1, 1);
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle_id();

    // ALU r5 in slot0, ready at 0: zero-latency forward from stage 0.
    adv = 1'b1;
    set_id(1'b1, 1'b1, 5, 0);
    #1; check_all("alu_alloc");
    tick();
    idle_id();
    adv = 1'b0;
    stg_data[0*DW +: DW] = 32'h0000_1234;
    set_rd(0, 1'b1, 5);
    #1; check_all("alu_fwd");
    n_asserts++;
    assert (fwd_rdata[DW-1:0] === 32'h0000_1234 && fwd_hit[0] === 1'b1 && stall === 1'b0) else begin
      n_fail++;
      $error("FAIL alu_fwd_const observed=%h/%b/%b expected=00001234/1/0",
             fwd_rdata[DW-1:0], fwd_hit[0], stall);
    end

    // Load r7 ready at 1: one advancing stall, then forward from stage 1.
    idle_id();
    adv = 1'b1;
    set_id(1'b1, 1'b1, 7, 1);
    #1; check_all("load_alloc");
    tick();
    set_id(1'b1, 1'b1, 9, 0);
    set_rd(0, 1'b1, 7);
    stg_data[1*DW +: DW] = 32'hCAFE_0007;
    #1; check_all("load_use_stall");
    n_asserts++;
    assert (stall === 1'b1) else begin
      n_fail++;
      $error("FAIL load_use_stall_const observed=%b expected=1", stall);
    end
    tick();
    #1; check_all("load_use_release");
    n_asserts++;
    assert (stall === 1'b0 && fwd_rdata[DW-1:0] === 32'hCAFE_0007) else begin
      n_fail++;
      $error("FAIL load_release_const observed=%b/%h expected=0/cafe0007", stall, fwd_rdata[DW-1:0]);
    end
    tick();

    // r3 written twice, both ready: port1 must see the younger (slot 0).
    idle_id();
    set_id(1'b1, 1'b1, 3, 0);
    tick();
    tick();
    idle_id();
    adv = 1'b0;
    stg_data[0*DW +: DW] = 32'h0000_AAAA;
    stg_data[1*DW +: DW] = 32'h0000_BBBB;
    set_rd(1, 1'b1, 3);
    #1; check_all("youngest_wins");
    n_asserts++;
    assert (fwd_rdata[DW +: DW] === 32'h0000_AAAA) else begin
      n_fail++;
      $error("FAIL youngest_const observed=%h expected=0000aaaa", fwd_rdata[DW +: DW]);
    end

    // r0: id_rw=0 never allocates, a read of r0 takes the regfile.
    idle_id();
    adv = 1'b1;
    set_id(1'b1, 1'b1, 0, 0);
    tick();
    idle_id();
    adv = 1'b0;
    set_rd(0, 1'b1, 0);
    set_rd(1, 1'b1, 0);
    #1; check_all("r0_read");

    // Load-use stall then flush: stall in flush cycle, gone after.
    idle_id();
    adv = 1'b1;
    set_id(1'b1, 1'b1, 12, 1);
    tick();
    set_id(1'b1, 1'b1, 13, 0);
    set_rd(0, 1'b1, 12);
    flush = 1'b1;
    #1; check_all("flush_cycle");
    tick();
    flush = 1'b0;
    #1; check_all("after_flush");
    n_asserts++;
    assert (stall === 1'b0 && fwd_hit === 2'b00 && fwd_rdata === rf_rdata) else begin
      n_fail++;
      $error("FAIL after_flush_const observed=%b/%b expected=0/00", stall, fwd_hit);
    end

    // Writer that never becomes ready (rdy >= DEPTH), held with adv=0.
    idle_id();
    adv = 1'b1;
    set_id(1'b1, 1'b1, 9, 3);
    tick();
    idle_id();
    adv = 1'b0;
    set_rd(1, 1'b1, 9);
    #1; check_all("hold_start");
    for (int k = 0; k < 5; k++) tick();
    check_all("hold_5");

    // Saturation: run up to 0xFFFE, then three more stalled cycles.
    while (m_cnt < 16'hFFFE) tick();
    check_all("cnt_fffe");
    for (int k = 0; k < 3; k++) tick();
    check_all("cnt_sat");
    n_asserts++;
    assert (stall_cnt === 16'hFFFF) else begin
      n_fail++;
      $error("FAIL cnt_sat_const observed=%h expected=ffff", stall_cnt);
    end

    // Asynchronous reset mid-operation: state clears before any edge.
    #3;
    rst_n = 1'b0;
    model_clear();
    m_cnt = 0;
    #1; check_all("async_reset");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic on a small register set to provoke matches.
    for (int k = 0; k < 400; k++) begin
      adv      = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      set_id($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3));
      for (int p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(0, 1), $urandom_range(0, 3));
      rf_rdata = {$urandom, $urandom};
      stg_data = {$urandom, $urandom, $urandom};
      #1; check_all("random");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
